// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and in-order load responses onto a
// single register-file write port, tracking outstanding load destinations.
module writeback_unit #(
  parameter int unsigned LQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rw_en,
  output logic [4:0]  rw_dest,
  output logic [31:0] rw_data,
  output logic [31:0] pending,
  output logic        lq_err
);

  localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [4:0]       lq_rd [LQ_DEPTH];
  logic [2:0]       lq_f3 [LQ_DEPTH];
  logic [1:0]       lq_lo [LQ_DEPTH];

  logic        accept, push, pop, orphan, alu_wr;
  logic [4:0]  head_rd;
  logic [31:0] load_data;
  logic [31:0] pending_next;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Handshake: stall on RAW against a queued load, full queue, or port conflict
  always_comb begin
    ex_ready = 1'b1;
    if (pending[ex_rd] && (ex_rd != 5'd0)) begin
      ex_ready = 1'b0;
    end else if (ex_is_load) begin
      if (count == CNT_W'(LQ_DEPTH)) ex_ready = 1'b0;
    end else if (mem_rvalid) begin
      ex_ready = 1'b0;
    end
  end

  // Transfer qualifiers
  always_comb begin
    accept  = ex_valid & ex_ready;
    push    = accept & ex_is_load;
    alu_wr  = accept & ~ex_is_load;
    pop     = mem_rvalid & (count != '0);
    orphan  = mem_rvalid & (count == '0);
    head_rd = lq_rd[head];
  end

  // Load data alignment and extension for the queue head
  always_comb begin
    sel_byte  = 8'h00;
    sel_half  = lq_lo[head][1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lq_lo[head])
      2'd0:    sel_byte = mem_rdata[7:0];
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    case (lq_f3[head])
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'h0, sel_byte};
      3'b101:  load_data = {16'h0, sel_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Scoreboard update: retire the popped head, then mark the newly queued load
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[head_rd] = 1'b0;
    if (push && (ex_rd != 5'd0)) pending_next[ex_rd] = 1'b1;
  end

  // Control state, scoreboard and write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      pending <= '0;
      lq_err  <= 1'b0;
      rw_en   <= 1'b0;
      rw_dest <= '0;
      rw_data <= '0;
    end else begin
      head    <= head + PTR_W'(pop);
      tail    <= tail + PTR_W'(push);
      count   <= count + CNT_W'(push) - CNT_W'(pop);
      pending <= pending_next;
      lq_err  <= lq_err | orphan;
      rw_en   <= 1'b0;
      if (pop) begin
        if (head_rd != 5'd0) begin
          rw_en   <= 1'b1;
          rw_dest <= head_rd;
          rw_data <= load_data;
        end
      end else if (alu_wr && (ex_rd != 5'd0)) begin
        rw_en   <= 1'b1;
        rw_dest <= ex_rd;
        rw_data <= ex_data;
      end
    end
  end

  // Load queue payload storage; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd[tail] <= ex_rd;
      lq_f3[tail] <= ex_funct3;
      lq_lo[tail] <= ex_addr_lo;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: queue-based reference model plus
// directed scenarios with literal expectations and a randomized phase.
module tb_writeback_unit;

  localparam int unsigned LQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_is_load = 1'b0, mem_rvalid = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_data = '0, mem_rdata = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [1:0]  ex_addr_lo = '0;
  logic        ex_ready, rw_en, lq_err;
  logic [4:0]  rw_dest;
  logic [31:0] rw_data, pending;

  writeback_unit #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_data(ex_data), .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rw_en(rw_en), .rw_dest(rw_dest), .rw_data(rw_data),
    .pending(pending), .lq_err(lq_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] lo;
  } ld_t;

  ld_t         q[$];
  logic        exp_en = 1'b0, exp_err = 1'b0;
  logic [4:0]  exp_dest = '0;
  logic [31:0] exp_data = '0;
  logic        obs_ready;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (q[i]) if (q[i].rd != 5'd0) p[q[i].rd] = 1'b1;
    return p;
  endfunction

  function automatic logic model_ready(input logic il, input logic [4:0] rd, input logic rv);
    logic [31:0] p = model_pending();
    if (rd != 5'd0 && p[rd]) return 1'b0;
    if (il) return (q.size() < LQ_DEPTH);
    return !rv;
  endfunction

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    logic [31:0] b, h;
    int unsigned bsh, hsh;
    bsh = 8 * int'(lo);
    hsh = (lo >= 2'd2) ? 16 : 0;
    b = (w >> bsh) & 32'hFF;
    h = (w >> hsh) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    exp_en = 1'b0; exp_dest = '0; exp_data = '0; exp_err = 1'b0;
  endtask

  // One clock of stimulus; checks ex_ready before the edge and all outputs after it
  task automatic step(input logic v, input logic il, input logic [4:0] rd, input logic [31:0] d,
                      input logic [2:0] f3, input logic [1:0] lo, input logic rv, input logic [31:0] rdat);
    logic mr;
    ld_t  e;
    @(negedge clk);
    ex_valid = v; ex_is_load = il; ex_rd = rd; ex_data = d;
    ex_funct3 = f3; ex_addr_lo = lo; mem_rvalid = rv; mem_rdata = rdat;
    #1;
    mr = model_ready(il, rd, rv);
    obs_ready = ex_ready;
    chk("ex_ready", 32'(ex_ready), 32'(mr));
    exp_en = 1'b0;
    if (rv) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.rd != 5'd0) begin
          exp_en = 1'b1; exp_dest = e.rd; exp_data = fmt(e.f3, e.lo, rdat);
        end
      end else begin
        exp_err = 1'b1;
      end
    end
    if (v && mr) begin
      if (il) begin
        e.rd = rd; e.f3 = f3; e.lo = lo;
        q.push_back(e);
      end else if (rd != 5'd0) begin
        exp_en = 1'b1; exp_dest = rd; exp_data = d;
      end
    end
    @(posedge clk);
    #1;
    chk("rw_en",   32'(rw_en),   32'(exp_en));
    chk("rw_dest", 32'(rw_dest), 32'(exp_dest));
    chk("rw_data", rw_data, exp_data);
    chk("pending", pending, model_pending());
    chk("lq_err",  32'(lq_err),  32'(exp_err));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    model_reset();
    #10;
    chk("reset_rw_en",   32'(rw_en), 32'd0);
    chk("reset_rw_dest", 32'(rw_dest), 32'd0);
    chk("reset_rw_data", rw_data, 32'd0);
    chk("reset_pending", pending, 32'd0);
    chk("reset_lq_err",  32'(lq_err), 32'd0);
    chk("reset_ready",   32'(ex_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    idle();

    // ALU writeback
    step(1'b1, 1'b0, 5'd5, 32'h12345678, 3'd0, 2'd0, 1'b0, 32'd0);
    chk("alu_en", 32'(rw_en), 32'd1);
    chk("alu_dest", 32'(rw_dest), 32'd5);
    chk("alu_data", rw_data, 32'h12345678);
    idle();
    chk("alu_en_drop", 32'(rw_en), 32'd0);
    chk("alu_hold", rw_data, 32'h12345678);

    // LB / LHU formatting and scoreboard
    step(1'b1, 1'b1, 5'd3, 32'd0, 3'b000, 2'd2, 1'b0, 32'd0);
    chk("lb_pend3", 32'(pending[3]), 32'd1);
    step(1'b1, 1'b1, 5'd4, 32'd0, 3'b101, 2'd2, 1'b0, 32'd0);
    chk("lhu_pend4", 32'(pending[4]), 32'd1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 32'h00800000);
    chk("lb_data", rw_data, 32'hFFFFFF80);
    chk("lb_clr3", 32'(pending[3]), 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 32'hBEEF0000);
    chk("lhu_data", rw_data, 32'h0000BEEF);
    chk("lhu_dest", 32'(rw_dest), 32'd4);

    // Port collision and RAW stall
    step(1'b1, 1'b1, 5'd6, 32'd0, 3'b010, 2'd0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 5'd7, 32'hAAAA5555, 3'd0, 2'd0, 1'b1, 32'hCAFEF00D);
    chk("coll_ready", 32'(obs_ready), 32'd0);
    chk("coll_load_dest", 32'(rw_dest), 32'd6);
    step(1'b1, 1'b0, 5'd7, 32'hAAAA5555, 3'd0, 2'd0, 1'b0, 32'd0);
    chk("coll_alu_dest", 32'(rw_dest), 32'd7);
    step(1'b1, 1'b1, 5'd8, 32'd0, 3'b010, 2'd0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 5'd8, 32'd1, 3'd0, 2'd0, 1'b0, 32'd0);
    chk("raw_stall", 32'(obs_ready), 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 32'h11223344);
    step(1'b1, 1'b0, 5'd8, 32'd1, 3'd0, 2'd0, 1'b0, 32'd0);
    chk("raw_release", 32'(obs_ready), 32'd1);

    // Full queue
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 5'(i), 32'd0, 3'b010, 2'd0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 5'd5, 32'd0, 3'b010, 2'd0, 1'b0, 32'd0);
    chk("full_ready", 32'(obs_ready), 32'd0);
    step(1'b1, 1'b1, 5'd5, 32'd0, 3'b010, 2'd0, 1'b1, 32'h00000100);
    chk("full_pop_same_cycle", 32'(obs_ready), 32'd0);
    chk("full_x1", 32'(rw_dest), 32'd1);
    step(1'b0, 1'b1, 5'd5, 32'd0, 3'b010, 2'd0, 1'b0, 32'd0);
    chk("full_freed", 32'(obs_ready), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 32'(i * 16));
      chk("full_order", 32'(rw_dest), 32'(i));
    end

    // x0 load and orphan response
    step(1'b1, 1'b1, 5'd0, 32'd0, 3'b010, 2'd0, 1'b0, 32'd0);
    chk("x0_pend", pending, 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 32'hDEADBEEF);
    chk("x0_no_write", 32'(rw_en), 32'd0);
    chk("x0_no_err", 32'(lq_err), 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 32'h0BADF00D);
    chk("orphan_err", 32'(lq_err), 32'd1);
    idle();
    chk("orphan_sticky", 32'(lq_err), 32'd1);

    // Asynchronous reset mid-operation
    step(1'b1, 1'b1, 5'd9, 32'd0, 3'b010, 2'd0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 5'd10, 32'd0, 3'b010, 2'd0, 1'b0, 32'd0);
    chk("pre_reset_pend", pending, 32'h00000600);
    @(posedge clk);
    #3 rst = 1'b0;
    ex_valid = 1'b0; mem_rvalid = 1'b0;
    #1;
    model_reset();
    chk("arst_pending", pending, 32'd0);
    chk("arst_rw_en", 32'(rw_en), 32'd0);
    chk("arst_lq_err", 32'(lq_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, 5'd9, 32'd0, 3'b010, 2'd0, 1'b0, 32'd0);
    chk("post_reset_ready", 32'(obs_ready), 32'd1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 32'h12121212);
    chk("post_reset_orphan", 32'(lq_err), 32'd1);

    // Randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      logic rv;
      rv = (q.size() == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           $urandom(), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), rv, $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
